// File: rtl/tt_pad_pkg.sv
// Shared pad configuration layout for the tile pad controller array.
package tt_pad_pkg;

  localparam int CFG_OE = 5;
  localparam int CFG_IE = 4;
  localparam int CFG_SL = 3;
  localparam int CFG_CS = 2;
  localparam int CFG_PD = 1;
  localparam int CFG_PU = 0;
  localparam int CFG_W  = 6;

  typedef struct packed {
    logic oe;
    logic ie;
    logic sl;
    logic cs;
    logic pd;
    logic pu;
  } pad_cfg_t;

  // Input enabled with pull-down, output disabled.
  localparam pad_cfg_t DEFAULT_CFG = 6'b010010;

endpackage

// File: rtl/tt_pad_ctrl_array_sync.sv
// One inbound pad channel: multi-flop synchroniser followed by a registered
// rising/falling edge detector.
module tt_pad_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic data,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stage;
  logic                   hist;
  logic                   rise_q;
  logic                   fall_q;

  // Edge pulses are registered against a history copy, so they trail data by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage  <= '0;
      hist   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      stage  <= {stage[SYNC_STAGES-2:0], raw};
      hist   <= stage[SYNC_STAGES-1];
      rise_q <= stage[SYNC_STAGES-1] & ~hist;
      fall_q <= ~stage[SYNC_STAGES-1] & hist;
    end
  end

  assign data = stage[SYNC_STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/tt_pad_ctrl_array.sv
// N-channel pad controller: serial shadow config with atomic load, registered
// outbound data, synchronised inbound data. Optional macro TT_PAD_LOOPBACK_EN adds lb_en.
module tt_pad_ctrl_array
  import tt_pad_pkg::*;
#(
  parameter int              NUM_CH      = 8,
  parameter int              SYNC_STAGES = 2,
  parameter logic [CFG_W-1:0] RST_CFG    = DEFAULT_CFG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_sin,
  input  logic              cfg_shift,
  input  logic              cfg_load,
`ifdef TT_PAD_LOOPBACK_EN
  input  logic              lb_en,
`endif
  output logic              cfg_sout,
  input  logic [NUM_CH-1:0] out_data,
  output logic [NUM_CH-1:0] in_data,
  output logic [NUM_CH-1:0] in_rise,
  output logic [NUM_CH-1:0] in_fall,
  input  logic [NUM_CH-1:0] pad_Y,
  output logic [NUM_CH-1:0] pad_A,
  output logic [NUM_CH-1:0] pad_OE,
  output logic [NUM_CH-1:0] pad_IE,
  output logic [NUM_CH-1:0] pad_SL,
  output logic [NUM_CH-1:0] pad_CS,
  output logic [NUM_CH-1:0] pad_PD,
  output logic [NUM_CH-1:0] pad_PU
);

  localparam int            W       = CFG_W * NUM_CH;
  localparam logic [W-1:0]  RST_ALL = {NUM_CH{RST_CFG}};

  logic [W-1:0]      shadow;
  logic [W-1:0]      active;
  logic [NUM_CH-1:0] a_q;
  logic [NUM_CH-1:0] src;
  logic [NUM_CH-1:0] raw;

  // A load in the same cycle as a shift captures the pre-shift shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= RST_ALL;
      active <= RST_ALL;
    end else begin
      if (cfg_load)  active <= shadow;
      if (cfg_shift) shadow <= {shadow[W-2:0], cfg_sin};
    end
  end

  assign cfg_sout = shadow[W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) a_q <= '0;
    else     a_q <= out_data & pad_OE;
  end

  // Gating with the live OE keeps A low in the very cycle OE is cleared.
  assign pad_A = a_q & pad_OE;

`ifdef TT_PAD_LOOPBACK_EN
  assign src = lb_en ? pad_A : pad_Y;
`else
  assign src = pad_Y;
`endif
  assign raw = src & pad_IE;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pad_cfg_t cfg;
    assign cfg       = active[CFG_W*k +: CFG_W];
    assign pad_OE[k] = cfg.oe;
    assign pad_IE[k] = cfg.ie;
    assign pad_SL[k] = cfg.sl;
    assign pad_CS[k] = cfg.cs;
    assign pad_PD[k] = cfg.pd;
    assign pad_PU[k] = cfg.pu;

    tt_pad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw[k]),
      .data (in_data[k]),
      .rise (in_rise[k]),
      .fall (in_fall[k])
    );
  end

endmodule

// File: tb/tb_tt_pad_ctrl_array.sv
// Self-checking bench for tt_pad_ctrl_array: directed vector table, hand-written
// corner sequences and a randomized run against a delay-queue reference model.
module tb_tt_pad_ctrl_array;
  import tt_pad_pkg::*;

  localparam int N = 8;
  localparam int S = 2;
  localparam int W = CFG_W * N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_sin, cfg_shift, cfg_load, cfg_sout;
  logic [N-1:0] out_data, in_data, in_rise, in_fall, pad_Y;
  logic [N-1:0] pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU;
`ifdef TT_PAD_LOOPBACK_EN
  logic         lb_en;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  tt_pad_ctrl_array #(.NUM_CH(N), .SYNC_STAGES(S), .RST_CFG(6'b010010)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_sin   (cfg_sin),
    .cfg_shift (cfg_shift),
    .cfg_load  (cfg_load),
`ifdef TT_PAD_LOOPBACK_EN
    .lb_en     (lb_en),
`endif
    .cfg_sout  (cfg_sout),
    .out_data  (out_data),
    .in_data   (in_data),
    .in_rise   (in_rise),
    .in_fall   (in_fall),
    .pad_Y     (pad_Y),
    .pad_A     (pad_A),
    .pad_OE    (pad_OE),
    .pad_IE    (pad_IE),
    .pad_SL    (pad_SL),
    .pad_CS    (pad_CS),
    .pad_PD    (pad_PD),
    .pad_PU    (pad_PU)
  );

  typedef struct {
    logic [5:0]   ch3_cfg;
    logic [5:0]   other_cfg;
    logic [N-1:0] out_val;
    logic [N-1:0] exp_oe, exp_ie, exp_sl, exp_cs, exp_pd, exp_pu, exp_a;
  } vec_t;

  vec_t         tbl[4];
  logic [W-1:0] vec;
  logic [N-1:0] prev_out, prev_oe;

  logic [W-1:0] m_shadow, m_active;
  logic [N-1:0] m_aq, m_raw, m_src, exp_a;
  logic [N-1:0] raw_q[$];
  logic         m_lb;

  task automatic check_output(input string name, input logic [N-1:0] actual,
                              input logic [N-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic shift, input logic load, input logic sin);
    cfg_shift = shift;
    cfg_load  = load;
    cfg_sin   = sin;
    tick();
    cfg_shift = 1'b0;
    cfg_load  = 1'b0;
  endtask

  task automatic shift_vector(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) apply_stimulus(1'b1, 1'b0, v[i]);
  endtask

  function automatic logic [W-1:0] replicate(input logic [5:0] c, input logic [5:0] c3);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[CFG_W*k +: CFG_W] = (k == 3) ? c3 : c;
    return r;
  endfunction

  function automatic logic [N-1:0] field(input logic [W-1:0] act, input int f);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = act[CFG_W*k + f];
    return r;
  endfunction

  function automatic logic [N-1:0] one_bit(input logic b);
    return {{(N-1){1'b0}}, b};
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cfg_sin = 1'b0; cfg_shift = 1'b0; cfg_load = 1'b0;
    out_data = '0;  pad_Y = '0;
`ifdef TT_PAD_LOOPBACK_EN
    lb_en = 1'b0;
`endif

    // Async reset must reach the pad controls before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_output("async_rst_ie", pad_IE, 8'hFF);
    check_output("async_rst_pd", pad_PD, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    check_output("rst_ie", pad_IE, 8'hFF);
    check_output("rst_pd", pad_PD, 8'hFF);
    check_output("rst_oe", pad_OE, 8'h00);
    check_output("rst_sl_cs_pu", pad_SL | pad_CS | pad_PU, 8'h00);
    check_output("rst_a", pad_A, 8'h00);
    check_output("rst_in_data", in_data, 8'h00);
    check_output("rst_edges", in_rise | in_fall, 8'h00);
    check_output("rst_sout", one_bit(cfg_sout), 8'h00);

    tbl[0] = '{6'b110000, 6'b010000, 8'hFF, 8'h08, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08};
    tbl[1] = '{6'b000001, 6'b101000, 8'h0F, 8'hF7, 8'h00, 8'hF7, 8'h00, 8'h00, 8'h08, 8'h07};
    tbl[2] = '{6'b011111, 6'b000000, 8'hAA, 8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
    tbl[3] = '{6'b100100, 6'b100010, 8'h55, 8'hFF, 8'h00, 8'h00, 8'h08, 8'hF7, 8'h00, 8'h55};

    prev_out = '0;
    prev_oe  = '0;
    for (int i = 0; i < 4; i++) begin
      vec = replicate(tbl[i].other_cfg, tbl[i].ch3_cfg);
      shift_vector(vec);
      check_output("tbl_sout", one_bit(cfg_sout), one_bit(vec[W-1]));
      apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output("tbl_oe", pad_OE, tbl[i].exp_oe);
      check_output("tbl_ie", pad_IE, tbl[i].exp_ie);
      check_output("tbl_sl", pad_SL, tbl[i].exp_sl);
      check_output("tbl_cs", pad_CS, tbl[i].exp_cs);
      check_output("tbl_pd", pad_PD, tbl[i].exp_pd);
      check_output("tbl_pu", pad_PU, tbl[i].exp_pu);
      check_output("tbl_a_at_load", pad_A, prev_out & prev_oe & tbl[i].exp_oe);
      out_data = tbl[i].out_val;
      tick();
      check_output("tbl_a", pad_A, tbl[i].exp_a);
      prev_out = tbl[i].out_val;
      prev_oe  = tbl[i].exp_oe;
    end

    // Single rising then falling edge on channel 2 with IE set everywhere.
    shift_vector(replicate(6'b010000, 6'b010000));
    apply_stimulus(1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    pad_Y = 8'h04;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check_output("rise_data", in_data, (t >= 2) ? 8'h04 : 8'h00);
      check_output("rise_pulse", in_rise, (t == 3) ? 8'h04 : 8'h00);
      check_output("rise_nofall", in_fall, 8'h00);
    end
    pad_Y = 8'h00;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check_output("fall_data", in_data, (t >= 2) ? 8'h00 : 8'h04);
      check_output("fall_pulse", in_fall, (t == 3) ? 8'h04 : 8'h00);
      check_output("fall_norise", in_rise, 8'h00);
    end

    // Shift and load together: active takes the pre-shift shadow.
    vec = replicate(6'b100000, 6'b100000);
    shift_vector(vec);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("sl_oe", pad_OE, 8'hFF);
    check_output("sl_ie", pad_IE, 8'h00);
    check_output("sl_pu", pad_PU, 8'h00);
    check_output("sl_sout", one_bit(cfg_sout), one_bit(vec[W-2]));
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("sl_post_pu", pad_PU, 8'hFF);
    check_output("sl_post_oe", pad_OE, 8'h00);

    // Reset part-way through a shift discards the partial shadow.
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check_output("midrst_async_pu", pad_PU, 8'h00);
    tick();
    rst = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1'b0);
    check_output("midrst_ie", pad_IE, 8'hFF);
    check_output("midrst_pd", pad_PD, 8'hFF);
    check_output("midrst_oe", pad_OE, 8'h00);
    check_output("midrst_pu", pad_PU, 8'h00);
    check_output("midrst_sout", one_bit(cfg_sout), 8'h00);

`ifdef TT_PAD_LOOPBACK_EN
    shift_vector(replicate(6'b110000, 6'b110000));
    apply_stimulus(1'b0, 1'b1, 1'b0);
    out_data = 8'h00;
    pad_Y    = 8'h00;
    lb_en    = 1'b1;
    repeat (4) tick();
    out_data = 8'h01;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check_output("lb_rise", in_data, (t >= 1 + S) ? 8'h01 : 8'h00);
    end
    out_data = 8'h00;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check_output("lb_fall", in_data, (t >= 1 + S) ? 8'h00 : 8'h01);
    end
    lb_en = 1'b0;
`endif

    // Randomized run against a reference built from delay queues.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_shadow = {N{6'b010010}};
    m_active = {N{6'b010010}};
    m_aq     = '0;
    m_lb     = 1'b0;
    raw_q.delete();
    for (int i = 0; i < S + 2; i++) raw_q.push_back('0);

    for (int cyc = 0; cyc < 400; cyc++) begin
      exp_a = m_aq & field(m_active, CFG_OE);
      check_output("rnd_a", pad_A, exp_a);
      check_output("rnd_oe", pad_OE, field(m_active, CFG_OE));
      check_output("rnd_ie", pad_IE, field(m_active, CFG_IE));
      check_output("rnd_sl", pad_SL, field(m_active, CFG_SL));
      check_output("rnd_cs", pad_CS, field(m_active, CFG_CS));
      check_output("rnd_pd", pad_PD, field(m_active, CFG_PD));
      check_output("rnd_pu", pad_PU, field(m_active, CFG_PU));
      check_output("rnd_sout", one_bit(cfg_sout), one_bit(m_shadow[W-1]));
      check_output("rnd_in_data", in_data, raw_q[raw_q.size()-S]);
      check_output("rnd_rise", in_rise,
                   raw_q[raw_q.size()-S-1] & ~raw_q[raw_q.size()-S-2]);
      check_output("rnd_fall", in_fall,
                   ~raw_q[raw_q.size()-S-1] & raw_q[raw_q.size()-S-2]);

      cfg_shift = 1'($urandom_range(0, 1));
      cfg_load  = ($urandom_range(0, 7) == 0);
      cfg_sin   = 1'($urandom_range(0, 1));
      out_data  = N'($urandom);
      if ($urandom_range(0, 3) == 0) pad_Y = N'($urandom);
`ifdef TT_PAD_LOOPBACK_EN
      if ($urandom_range(0, 15) == 0) lb_en = ~lb_en;
      m_lb = lb_en;
`endif

      m_src = m_lb ? exp_a : pad_Y;
      m_raw = m_src & field(m_active, CFG_IE);
      raw_q.push_back(m_raw);
      if (raw_q.size() > 8) void'(raw_q.pop_front());
      m_aq = out_data & field(m_active, CFG_OE);
      if (cfg_load)  m_active = m_shadow;
      if (cfg_shift) m_shadow = {m_shadow[W-2:0], cfg_sin};

      tick();
      cfg_shift = 1'b0;
      cfg_load  = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tt_pad_ctrl_array.md
Name: tt_pad_ctrl_array

Overview:
- Parametrised N-channel pad controller for tile I/O.
- Drives per-pad control lines: A, OE, IE, SL, CS, PD, PU. Receives pad Y.
- Holds per-channel pad configuration, loaded through a serial shadow chain with an atomic load.
- Registers outbound data and synchronises inbound data, with rising/falling edge pulses.
- Sits between tile user logic and the GF pad ring; successor to the single-signal cell macro.

Parameters:
- NUM_CH, 8, number of signal pads controlled (1..32).
- SYNC_STAGES, 2, synchroniser flops on each inbound pad path (2..4).
- RST_CFG, 6'b010010, per-channel config value at reset: {OE,IE,SL,CS,PD,PU}. Default is input enabled, pull-down on.

Ports:
- clk  in  1  block clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_sin  in  1  serial config data in.
- cfg_shift  in  1  shift shadow chain one bit this cycle.
- cfg_load  in  1  copy shadow chain into active config.
- cfg_sout  out  1  serial config data out (shadow MSB), for daisy-chaining.
- out_data  in  NUM_CH  data to drive on pads.
- in_data  out  NUM_CH  synchronised pad input.
- in_rise  out  NUM_CH  one-cycle pulse on synchronised 0->1.
- in_fall  out  NUM_CH  one-cycle pulse on synchronised 1->0.
- pad_Y  in  NUM_CH  raw pad input.
- pad_A, pad_OE, pad_IE, pad_SL, pad_CS, pad_PD, pad_PU  out  NUM_CH each  pad controls.

Behaviour:
- Config layout:
  - W = 6*NUM_CH. Channel k occupies shadow/active bits [6k+5:6k] = {OE,IE,SL,CS,PD,PU}.
- Shadow chain:
  - On cfg_shift: shadow <= {shadow[W-2:0], cfg_sin}.
  - cfg_sout = shadow[W-1], combinational from the register.
  - The first bit shifted in lands at channel NUM_CH-1 OE after W shifts.
- Active config:
  - On cfg_load: active <= shadow.
  - If cfg_load and cfg_shift are high in the same cycle, active takes the pre-shift shadow value, and the shadow still shifts.
  - Pad control outputs are driven directly from active registers; they change 1 cycle after cfg_load.
- Output data:
  - pad_A[k] <= out_data[k] & active OE[k]; 1-cycle latency.
  - pad_A is 0 whenever OE is 0, including the cycle OE is cleared.
- Input path:
  - raw[k] = pad_Y[k] & active IE[k].
  - raw passes through SYNC_STAGES flops; in_data = last stage, so latency is SYNC_STAGES cycles.
  - in_rise / in_fall are computed against one extra history flop, giving latency SYNC_STAGES+1 cycles.
  - Pulses are exactly one cycle wide and never both high together.
  - Clearing IE forces raw to 0, so a falling pulse is generated if in_data was 1.
- Reset (async assert, released synchronously by the environment):
  - shadow = all copies of RST_CFG; active = all copies of RST_CFG.
  - pad_A = 0; all sync and history flops = 0.
  - in_data, in_rise, in_fall = 0.
  - pad controls reflect RST_CFG immediately on reset assertion.
- Reset mid-shift: the partial shadow is discarded and returns to RST_CFG; no load occurs.
- Channels are fully independent; there is no cross-channel arithmetic.

Optional Feature:
- Macro: TT_PAD_LOOPBACK_EN.
- Defined:
  - Adds input port lb_en (1 bit).
  - When lb_en=1, raw[k] = pad_A[k] & active IE[k], replacing pad_Y, for all channels.
  - lb_en is sampled combinationally into the first synchroniser stage.
  - Pad controls are unchanged.
- Undefined: port absent; raw always from pad_Y.

Decomposition:
- Package tt_pad_pkg:
  - Field index constants CFG_OE=5, CFG_IE=4, CFG_SL=3, CFG_CS=2, CFG_PD=1, CFG_PU=0.
  - CFG_W=6.
  - Typedef for a 6-bit pad config struct.
  - Default reset config constant.
- Sub-module tt_pad_sync: one channel of SYNC_STAGES synchroniser plus edge detector, instantiated NUM_CH times in a generate loop.

Test Plan:
- Reset with NUM_CH=8 -> pad_IE=8'hFF, pad_PD=8'hFF, pad_OE=0, pad_A=0, in_data=0, cfg_sout=0 (RST_CFG MSB).
- Shift 48 bits so that ch3 = 6'b110000 and all others = 6'b010000, then pulse cfg_load -> 1 cycle later pad_OE=8'h08, pad_IE=8'hFF, pad_PD=0. With out_data=8'hFF, the next cycle gives pad_A=8'h08.
- Drive pad_Y[2] 0->1 with IE set, SYNC_STAGES=2 -> in_data[2] rises 2 cycles later; in_rise[2] is a single 1-cycle pulse at cycle 3. Drive it back to 0 -> in_fall[2] is a single pulse.
- cfg_shift and cfg_load in the same cycle -> active equals the pre-shift shadow; cfg_sout presents the shifted MSB next cycle.
- Assert rst after 20 of 48 shifts, deassert, then load -> active equals RST_CFG on all channels.
- With TT_PAD_LOOPBACK_EN, lb_en=1, ch0 OE=IE=1, out_data[0] toggled, pad_Y held at 0 -> in_data[0] follows out_data[0] with latency 1+SYNC_STAGES cycles.
